// File: rtl/branch_trap_unit.sv
// rtl/branch_trap_unit.sv - Bicc/Ticc condition evaluation, window overflow detection and trap sequencing
module branch_trap_unit #(
   parameter  int NWINDOWS = 8,
   localparam int CWPW     = $clog2(NWINDOWS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                valid_in,
   input  logic [31:0]         ir,
   input  logic [6:0]          rs_sum,
   input  logic                icc_wr,
   input  logic [3:0]          icc_in,
   input  logic [CWPW-1:0]     cwp,
   input  logic [NWINDOWS-1:0] wim,
   input  logic                trap_ack,
   output logic                bcond,
   output logic                annul,
   output logic                trap_req,
   output logic [7:0]          tt,
   output logic [3:0]          icc,
   output logic                busy
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_PEND  = 2'b01;
   localparam logic [1:0] ST_FLUSH = 2'b10;

   logic [1:0]      state;
   logic [3:0]      flags;
   logic            base_cond;
   logic            taken;
   logic            is_bicc;
   logic            is_ticc;
   logic            is_save;
   logic            is_restore;
   logic            accept;
   logic [CWPW-1:0] cwp_dec;
   logic [CWPW-1:0] cwp_inc;
   logic            trap_hit;
   logic [7:0]      trap_tt;
   logic            unused_bits;

   assign unused_bits = ^ir[18:0];

   // Same-cycle icc_wr forwards the ALU flags so a dependent branch sees them.
   assign flags = icc_wr ? icc_in : icc;

   // cond[3] inverts the sense of the lower seven tests.
   always_comb begin
      base_cond = 1'b0;
      case (ir[27:25])
         3'b000:  base_cond = 1'b0;
         3'b001:  base_cond = flags[2];
         3'b010:  base_cond = flags[2] | (flags[3] ^ flags[1]);
         3'b011:  base_cond = flags[3] ^ flags[1];
         3'b100:  base_cond = flags[0] | flags[2];
         3'b101:  base_cond = flags[0];
         3'b110:  base_cond = flags[3];
         default: base_cond = flags[1];
      endcase
   end

   assign taken = base_cond ^ ir[28];

   assign is_bicc    = (ir[31:30] == 2'b00) && (ir[24:22] == 3'b010);
   assign is_ticc    = (ir[31:30] == 2'b10) && (ir[24:19] == 6'b111010);
   assign is_save    = (ir[31:30] == 2'b10) && (ir[24:19] == 6'b111100);
   assign is_restore = (ir[31:30] == 2'b10) && (ir[24:19] == 6'b111101);

   assign accept = valid_in && (state == ST_IDLE);

   assign cwp_dec = (cwp == '0) ? CWPW'(NWINDOWS - 1) : cwp - CWPW'(1);
   assign cwp_inc = (cwp == CWPW'(NWINDOWS - 1)) ? '0 : cwp + CWPW'(1);

   always_comb begin
      trap_hit = 1'b0;
      trap_tt  = 8'h00;
      if (accept) begin
         if (is_ticc && taken) begin
            trap_hit = 1'b1;
            trap_tt  = 8'h80 + {1'b0, rs_sum};
         end else if (is_save && wim[cwp_dec]) begin
            trap_hit = 1'b1;
            trap_tt  = 8'h05;
         end else if (is_restore && wim[cwp_inc]) begin
            trap_hit = 1'b1;
            trap_tt  = 8'h06;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         bcond    <= 1'b0;
         annul    <= 1'b0;
         trap_req <= 1'b0;
         tt       <= 8'h00;
         icc      <= 4'h0;
      end else begin
         if (icc_wr) begin
            icc <= icc_in;
         end
         case (state)
            ST_IDLE: begin
               bcond <= accept && is_bicc && taken;
               annul <= accept && is_bicc && ir[29] && (!taken || (ir[28:25] == 4'b1000));
               if (trap_hit) begin
                  tt       <= trap_tt;
                  trap_req <= 1'b1;
                  state    <= ST_PEND;
               end
            end
            ST_PEND: begin
               bcond <= 1'b0;
               annul <= 1'b0;
               if (trap_ack) begin
                  trap_req <= 1'b0;
                  annul    <= 1'b1;
                  state    <= ST_FLUSH;
               end
            end
            default: begin
               bcond <= 1'b0;
               annul <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

endmodule
